alu_sequencer: RTL

- Initiator side of the 32-bit ALU interface (A, B, ALUOp -> C).
- Accepts operation requests over a valid/ready handshake and drives the combinational ALU's A/B/ALUOp inputs.
- Captures C and returns the result over a valid/ready response channel.
- Adds a multi-cycle unsigned multiply (low 32 bits) built by sequencing the ALU's add operation, 32 shift-add steps.

---
 rtl/alu_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Initiator for a combinational 32-bit ALU: valid/ready requests in, registered results out.
// MUL is built from MUL_STEPS shift-add iterations through the ALU's add operation.
module alu_sequencer #(
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned W     = 32;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ILL = OP_W'(7);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t           state;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [OP_W-1:0]  op_r;
  logic [W-1:0]     acc;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic [CNT_W-1:0] cnt;

  // Sequencer state, operand latches and the registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_r  <= req_a;
            b_r  <= req_b;
            op_r <= req_op;
            if (req_op == OP_MUL) begin
              acc    <= '0;
              mcand  <= req_a;
              mplier <= req_b;
              cnt    <= '0;
              state  <= MUL;
            end else if (req_op == OP_ILL) begin
              resp_data  <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          resp_data  <= alu_c;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        MUL: begin
          // Fixed-length loop: no early exit when the multiplier runs out of ones
          acc    <= alu_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MUL_STEPS - 1)) begin
            resp_data  <= alu_c;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive depends on registered state only; ops 6/7 never reach alu_op
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_ADD;
    case (state)
      EXEC: begin
        alu_a  = a_r;
        alu_b  = b_r;
        alu_op = op_r;
      end
      MUL: begin
        alu_a  = acc;
        alu_b  = mplier[0] ? mcand : '0;
        alu_op = OP_ADD;
      end
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule
